apb_native_bridge: RTL and testbench
====================================

// Module: apb_native_bridge
// PURPOSE
//  APB4 slave to multi-port reg_native_if bridge, next-generation register-access front end.
//  Decodes a port index from paddr, forwards one-cycle request pulses to that port, waits for its ack.
//  Built-in timeout counter, byte strobes, registered response with PREADY/PSLVERR.
//  Sits between the SoC APB fabric and NUM_PORT register-block slices.
// PARAMETERS
//  ADDR_WIDTH    48            paddr / fwd_addr width
//  DATA_WIDTH    32            data width (multiple of 8)
//  NUM_PORT      4             downstream native ports (1..16)
//  PORT_SEL_LSB  16            port index = paddr[PORT_SEL_LSB +: PSW], PSW = max(1,$clog2(NUM_PORT))
//  TMOUT_W       16            timeout counter width
//  ERR_DATA      32'hdead_1eaf prdata returned on timeout or decode error (zero-extended/truncated to DATA_WIDTH)
// PORTS
//  pclk            in   1                   clock
//  presetn         in   1                   async reset, active-low
//  psel/penable    in   1                   APB select / enable
//  pwrite          in   1                   APB direction
//  paddr           in   ADDR_WIDTH          APB address
//  pwdata          in   DATA_WIDTH          APB write data
//  pstrb           in   DATA_WIDTH/8        APB4 write strobes
//  pprot           in   3                   APB protection; pprot[1] = non-secure
//  pready          out  1                   transfer complete
//  pslverr         out  1                   error, valid only with pready
//  prdata          out  DATA_WIDTH          read data, valid only with pready
//  pslverr_en      in   1                   1 = errors reported on pslverr
//  tmout_val       in   TMOUT_W             timeout in cycles; 0 = timeout disabled
//  fwd_req_vld     out  NUM_PORT            one-hot request pulse
//  fwd_ack_vld     in   NUM_PORT            per-port ack
//  fwd_addr        out  ADDR_WIDTH          shared, paddr during setup, else 0
//  fwd_wr_en/rd_en out  1                   shared pulses
//  fwd_wr_data     out  DATA_WIDTH          shared, pwdata during setup, else 0
//  fwd_wr_strb     out  DATA_WIDTH/8        pstrb on write setup, else 0
//  fwd_non_sec     out  1                   pulse, setup & pprot[1]
//  fwd_rd_data     in   NUM_PORT*DATA_WIDTH per-port read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//  fwd_err         in   NUM_PORT            per-port error, sampled with its ack
//  tmout_evt       out  1                   one-cycle pulse on timeout
// BEHAVIOUR
//  setup = psel & ~penable; fwd_* outputs combinational from setup, all others registered. Reset: every output 0.
//  Index >= NUM_PORT: decode error, no fwd_* pulses.
//  FSM (S_IDLE, S_WAIT, S_RESP; reset S_IDLE):
//   IDLE: setup & decode err -> RESP (err=1, rdata=ERR_DATA); setup & ack[sel] same cycle -> RESP capture;
//         setup otherwise -> WAIT, latch sel/pwrite, cnt=0; acks with no request ignored.
//   WAIT: ack[sel] -> RESP, capture rdata=fwd_rd_data[sel] (0 on write), err=fwd_err[sel];
//         else tmout_val!=0 & cnt==tmout_val-1 -> RESP, rdata=ERR_DATA, err=1, tmout_evt=1; else cnt++.
//         ack and timeout same cycle: ack wins. Acks from non-selected ports ignored. psel drop ignored.
//   RESP: pready=1, prdata=rdata reg, pslverr=err & pslverr_en; -> IDLE (setup here waits for IDLE).
//  Latency: ack in setup cycle -> pready in access cycle (zero wait); ack N cycles later -> pready N+1 after setup.
//  prdata=0 and pslverr=0 whenever pready=0. cnt saturates at all-ones when tmout_val=0.
//  Reset mid-transfer: FSM IDLE, cnt 0, capture regs 0; no response for the aborted transfer.
// CONFIGURATION
//  APB_NATIVE_BRIDGE_TMOUT_LOG_EN defined: adds out tmout_cnt[15:0] (saturating timeout count) and
//  tmout_addr[ADDR_WIDTH-1:0] (paddr of last timed-out transfer), both reset 0, updated with tmout_evt.
//  Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  apb_native_bridge_pkg: state_e enum, DEF_ERR_DATA constant, port-index width function.
//  Sub-module apb_native_tmout_cnt: clear/enable counter, compare with tmout_val, hit output.
// TESTING
//  Read port 2, ack in setup cycle, rd_data=32'h1234_5678 -> pready in access cycle, prdata 32'h1234_5678, pslverr 0.
//  Write port 0, pstrb=4'b0101, ack 3 cycles later -> fwd_wr_strb 4'b0101 one cycle, pready 4 cycles after setup.
//  tmout_val=8, no ack, pslverr_en=1 -> tmout_evt, pready at setup+9, prdata 32'hdead_1eaf, pslverr 1.
//  paddr index 5 with NUM_PORT=4 -> no fwd_req_vld, pready next cycle, ERR_DATA, pslverr=pslverr_en.
//  Ack on port 1 while port 3 selected, then ack on port 3 with fwd_err=1 -> only port 3 completes, pslverr 1.
//  Reset in S_WAIT then read port 1 -> clean transfer, timeout counter restarts at 0.

Source files
------------

// File: rtl/apb_native_bridge_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_native_bridge_pkg : shared types and constants for the APB native bridge
// Rev 1.0
// ---------------------------------------------------------------------------
package apb_native_bridge_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [31:0] DEF_ERR_DATA = 32'hdead_1eaf;

   // The selector field is decoded 4 bits wide (up to 16 ports) so indices
   // that would alias onto a real port with fewer ports are still rejected.
   localparam int SEL_FIELD_W = 4;

   function automatic int port_sel_w(input int num_port);
      return (num_port > 1) ? $clog2(num_port) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_native_bridge_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_native_bridge_if : APB4 completer-side bus bundle with master/slave views
// Rev 1.0
// ---------------------------------------------------------------------------
interface apb_native_bridge_if #(
   parameter int ADDR_WIDTH = 48,
   parameter int DATA_WIDTH = 32
);
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [2:0]              pprot;
   logic                    pready;
   logic                    pslverr;
   logic [DATA_WIDTH-1:0]   prdata;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      input  pready, pslverr, prdata
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      output pready, pslverr, prdata
   );
endinterface
`default_nettype wire

// File: rtl/apb_native_tmout_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_native_tmout_cnt : saturating wait counter with programmable timeout hit
// Rev 1.0
// ---------------------------------------------------------------------------
module apb_native_tmout_cnt #(
   parameter int TMOUT_W = 16
) (
   input  wire logic               pclk,
   input  wire logic               presetn,
   input  wire logic               clr_i,
   input  wire logic               en_i,
   input  wire logic [TMOUT_W-1:0] tmout_val_i,
   output logic                    hit_o
);
   logic [TMOUT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !(&cnt_q))
         cnt_d = cnt_q + TMOUT_W'(1);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // A zero timeout value disables the hit entirely.
   assign hit_o = (tmout_val_i != '0) && (cnt_q == tmout_val_i - TMOUT_W'(1));

endmodule
`default_nettype wire

// File: rtl/apb_native_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_native_bridge : APB4 slave to multi-port reg_native bridge with timeout
// Rev 1.0 | APB_NATIVE_BRIDGE_TMOUT_LOG_EN adds tmout_cnt_o / tmout_addr_o
// ---------------------------------------------------------------------------
module apb_native_bridge
   import apb_native_bridge_pkg::*;
#(
   parameter int          ADDR_WIDTH   = 48,
   parameter int          DATA_WIDTH   = 32,
   parameter int          NUM_PORT     = 4,
   parameter int          PORT_SEL_LSB = 16,
   parameter int          TMOUT_W      = 16,
   parameter logic [31:0] ERR_DATA     = DEF_ERR_DATA
) (
   input  wire logic                           pclk,
   input  wire logic                           presetn,
   apb_native_bridge_if.slave                  apb,
   input  wire logic                           pslverr_en_i,
   input  wire logic [TMOUT_W-1:0]             tmout_val_i,
   output logic [NUM_PORT-1:0]                 fwd_req_vld_o,
   input  wire logic [NUM_PORT-1:0]            fwd_ack_vld_i,
   output logic [ADDR_WIDTH-1:0]               fwd_addr_o,
   output logic                                fwd_wr_en_o,
   output logic                                fwd_rd_en_o,
   output logic [DATA_WIDTH-1:0]               fwd_wr_data_o,
   output logic [DATA_WIDTH/8-1:0]             fwd_wr_strb_o,
   output logic                                fwd_non_sec_o,
   input  wire logic [NUM_PORT*DATA_WIDTH-1:0] fwd_rd_data_i,
   input  wire logic [NUM_PORT-1:0]            fwd_err_i,
   output logic                                tmout_evt_o
`ifdef APB_NATIVE_BRIDGE_TMOUT_LOG_EN
   ,
   output logic [15:0]                         tmout_cnt_o,
   output logic [ADDR_WIDTH-1:0]               tmout_addr_o
`endif
);
   localparam int                    PSW       = port_sel_w(NUM_PORT);
   localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_DATA);

   state_e                 state_q;
   logic [PSW-1:0]         sel_q;
   logic                   wr_q;
   logic                   pready_q, pslverr_q, tmout_evt_q;
   logic [DATA_WIDTH-1:0]  prdata_q;

   logic [SEL_FIELD_W-1:0] sel_field;
   logic [PSW-1:0]         idx, cur_sel;
   logic                   setup, go, dec_err, fwd_ok, cur_wr;
   logic                   ack_hit, tmo_hit, tmo_fire;
   logic [DATA_WIDTH-1:0]  cap_rdata;
   logic [DATA_WIDTH-1:0]  rd_arr [NUM_PORT];
   logic                   unused_pprot;

   for (genvar p = 0; p < NUM_PORT; p++) begin : g_rd_unpack
      assign rd_arr[p] = fwd_rd_data_i[p*DATA_WIDTH +: DATA_WIDTH];
   end

   assign sel_field = apb.paddr[PORT_SEL_LSB +: SEL_FIELD_W];
   assign idx       = sel_field[PSW-1:0];
   assign dec_err   = 32'(sel_field) >= NUM_PORT;
   assign setup     = apb.psel & ~apb.penable;
   assign go        = setup & (state_q == S_IDLE);
   assign fwd_ok    = go & ~dec_err;

   assign fwd_req_vld_o = fwd_ok ? (NUM_PORT'(1) << idx) : '0;
   assign fwd_addr_o    = go ? apb.paddr : '0;
   assign fwd_wr_en_o   = fwd_ok & apb.pwrite;
   assign fwd_rd_en_o   = fwd_ok & ~apb.pwrite;
   assign fwd_wr_data_o = go ? apb.pwdata : '0;
   assign fwd_wr_strb_o = (go & apb.pwrite) ? apb.pstrb : '0;
   assign fwd_non_sec_o = fwd_ok & apb.pprot[1];
   assign unused_pprot  = apb.pprot[0] ^ apb.pprot[2];

   // In the setup cycle the live address selects the port; afterwards the latched one.
   assign cur_sel   = (state_q == S_IDLE) ? idx : sel_q;
   assign cur_wr    = (state_q == S_IDLE) ? apb.pwrite : wr_q;
   assign ack_hit   = fwd_ack_vld_i[cur_sel];
   assign cap_rdata = cur_wr ? '0 : rd_arr[cur_sel];
   assign tmo_fire  = (state_q == S_WAIT) & ~ack_hit & tmo_hit;

   apb_native_tmout_cnt #(.TMOUT_W(TMOUT_W)) u_tmout_cnt (
      .pclk        (pclk),
      .presetn     (presetn),
      .clr_i       (state_q != S_WAIT),
      .en_i        (state_q == S_WAIT),
      .tmout_val_i (tmout_val_i),
      .hit_o       (tmo_hit)
   );

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         wr_q        <= 1'b0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         pslverr_q   <= 1'b0;
         tmout_evt_q <= 1'b0;
      end else begin
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         pslverr_q   <= 1'b0;
         tmout_evt_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (setup) begin
                  sel_q <= idx;
                  wr_q  <= apb.pwrite;
                  if (dec_err) begin
                     state_q   <= S_RESP;
                     pready_q  <= 1'b1;
                     prdata_q  <= ERR_RDATA;
                     pslverr_q <= pslverr_en_i;
                  end else if (ack_hit) begin
                     state_q   <= S_RESP;
                     pready_q  <= 1'b1;
                     prdata_q  <= cap_rdata;
                     pslverr_q <= fwd_err_i[cur_sel] & pslverr_en_i;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (ack_hit) begin
                  state_q   <= S_RESP;
                  pready_q  <= 1'b1;
                  prdata_q  <= cap_rdata;
                  pslverr_q <= fwd_err_i[cur_sel] & pslverr_en_i;
               end else if (tmo_fire) begin
                  state_q     <= S_RESP;
                  pready_q    <= 1'b1;
                  prdata_q    <= ERR_RDATA;
                  pslverr_q   <= pslverr_en_i;
                  tmout_evt_q <= 1'b1;
               end
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign apb.pready  = pready_q;
   assign apb.prdata  = prdata_q;
   assign apb.pslverr = pslverr_q;
   assign tmout_evt_o = tmout_evt_q;

`ifdef APB_NATIVE_BRIDGE_TMOUT_LOG_EN
   logic [ADDR_WIDTH-1:0] addr_q, tmout_addr_q;
   logic [15:0]           tmout_cnt_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         addr_q       <= '0;
         tmout_addr_q <= '0;
         tmout_cnt_q  <= '0;
      end else begin
         if (go)
            addr_q <= apb.paddr;
         if (tmo_fire) begin
            tmout_addr_q <= addr_q;
            if (!(&tmout_cnt_q))
               tmout_cnt_q <= tmout_cnt_q + 16'd1;
         end
      end
   end

   assign tmout_cnt_o  = tmout_cnt_q;
   assign tmout_addr_o = tmout_addr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_native_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_native_bridge : directed transfers checked every cycle against a
// transaction-level response model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_apb_native_bridge;
   localparam int          NP    = 4;
   localparam int          DW    = 32;
   localparam int          AW    = 48;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] ERRD  = 32'hdead_1eaf;

   bit                 pclk = 1'b0;
   logic               presetn = 1'b1;
   logic               pslverr_en;
   logic [15:0]        tmout_val;
   logic [NP-1:0]      fwd_req_vld, ack, ferr;
   logic [AW-1:0]      fwd_addr;
   logic               fwd_wr_en, fwd_rd_en, fwd_non_sec, tmout_evt;
   logic [DW-1:0]      fwd_wr_data;
   logic [DW/8-1:0]    fwd_wr_strb;
   logic [NP*DW-1:0]   rdv;
`ifdef APB_NATIVE_BRIDGE_TMOUT_LOG_EN
   logic [15:0]        tmout_cnt;
   logic [AW-1:0]      tmout_addr;
`endif

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   // expected outputs per cycle; zero unless a transfer says otherwise
   bit          e_pready [DEPTH];
   bit [31:0]   e_prdata [DEPTH];
   bit          e_pslverr[DEPTH];
   bit          e_evt    [DEPTH];
   bit [3:0]    e_req    [DEPTH];
   bit [47:0]   e_addr   [DEPTH];
   bit [31:0]   e_wdata  [DEPTH];
   bit [3:0]    e_strb   [DEPTH];
   bit          e_wen    [DEPTH];
   bit          e_ren    [DEPTH];
   bit          e_ns     [DEPTH];

   apb_native_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_if ();

   apb_native_bridge dut (
      .pclk          (pclk),
      .presetn       (presetn),
      .apb           (apb_if),
      .pslverr_en_i  (pslverr_en),
      .tmout_val_i   (tmout_val),
      .fwd_req_vld_o (fwd_req_vld),
      .fwd_ack_vld_i (ack),
      .fwd_addr_o    (fwd_addr),
      .fwd_wr_en_o   (fwd_wr_en),
      .fwd_rd_en_o   (fwd_rd_en),
      .fwd_wr_data_o (fwd_wr_data),
      .fwd_wr_strb_o (fwd_wr_strb),
      .fwd_non_sec_o (fwd_non_sec),
      .fwd_rd_data_i (rdv),
      .fwd_err_i     (ferr),
      .tmout_evt_o   (tmout_evt)
`ifdef APB_NATIVE_BRIDGE_TMOUT_LOG_EN
      ,
      .tmout_cnt_o   (tmout_cnt),
      .tmout_addr_o  (tmout_addr)
`endif
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   function automatic logic [47:0] paddr_of(input int f);
      return 48'h0001_0000_0c04 | (48'(f) << 16);
   endfunction

   task automatic fill_setup(input int s, input bit wr, input int field,
                             input logic [31:0] wdata, input logic [3:0] strb, input bit ns);
      bit dec = (field >= NP);
      e_req[s]   = dec ? 4'b0 : 4'(1 << field);
      e_addr[s]  = paddr_of(field);
      e_wdata[s] = wdata;
      e_strb[s]  = wr ? strb : 4'b0;
      e_wen[s]   = wr & ~dec;
      e_ren[s]   = ~wr & ~dec;
      e_ns[s]    = ns & ~dec;
   endtask

   // One APB transfer. dly = cycles after setup at which the selected port
   // acks (-1: never); spur = port that acks spuriously one cycle after setup.
   task automatic xfer(input bit wr, input int field, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit ns, input int dly,
                       input logic [31:0] rdata, input bit err, input int tmo,
                       input bit en, input int spur, output int s, output int r);
      logic [31:0] rd;
      bit er, ev;
      s = cyc;
      if (field >= NP) begin
         r = s + 1; rd = ERRD; er = 1'b1; ev = 1'b0;
      end else if (dly >= 0 && (tmo == 0 || dly <= tmo)) begin
         r = s + dly + 1; rd = wr ? 32'h0 : rdata; er = err; ev = 1'b0;
      end else begin
         r = s + tmo + 1; rd = ERRD; er = 1'b1; ev = 1'b1;
      end
      fill_setup(s, wr, field, wdata, strb, ns);
      e_pready[r] = 1'b1; e_prdata[r] = rd; e_pslverr[r] = er & en; e_evt[r] = ev;
      pslverr_en = en;
      tmout_val  = 16'(tmo);
      for (int k = 0; k <= r - s; k++) begin
         if (k > 0) tick();
         apb_if.psel    = 1'b1;
         apb_if.penable = (k > 0);
         apb_if.pwrite  = wr;
         apb_if.paddr   = paddr_of(field);
         apb_if.pwdata  = wdata;
         apb_if.pstrb   = strb;
         apb_if.pprot   = {1'b0, ns, 1'b0};
         ack = '0; ferr = '0;
         if (dly >= 0 && k == dly) begin
            ack[field] = 1'b1; ferr[field] = err; rdv[field*DW +: DW] = rdata;
         end
         if (spur >= 0 && k == 1) begin
            ack[spur] = 1'b1; ferr[spur] = 1'b1; rdv[spur*DW +: DW] = 32'hbad0_0000 | 32'(spur);
         end
      end
      tick();
      apb_if.psel = 1'b0; apb_if.penable = 1'b0; ack = '0; ferr = '0;
   endtask

   always @(negedge pclk) begin
      if (cyc < DEPTH) begin
         check("pready",      64'(apb_if.pready),  64'(e_pready[cyc]));
         check("prdata",      64'(apb_if.prdata),  64'(e_prdata[cyc]));
         check("pslverr",     64'(apb_if.pslverr), 64'(e_pslverr[cyc]));
         check("tmout_evt",   64'(tmout_evt),      64'(e_evt[cyc]));
         check("fwd_req_vld", 64'(fwd_req_vld),    64'(e_req[cyc]));
         check("fwd_addr",    64'(fwd_addr),       64'(e_addr[cyc]));
         check("fwd_wr_data", 64'(fwd_wr_data),    64'(e_wdata[cyc]));
         check("fwd_wr_strb", 64'(fwd_wr_strb),    64'(e_strb[cyc]));
         check("fwd_wr_en",   64'(fwd_wr_en),      64'(e_wen[cyc]));
         check("fwd_rd_en",   64'(fwd_rd_en),      64'(e_ren[cyc]));
         check("fwd_non_sec", 64'(fwd_non_sec),    64'(e_ns[cyc]));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, r;
      apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
      apb_if.paddr = '0; apb_if.pwdata = '0; apb_if.pstrb = '0; apb_if.pprot = '0;
      ack = '0; ferr = '0; pslverr_en = 1'b0; tmout_val = '0;
      for (int p = 0; p < NP; p++) rdv[p*DW +: DW] = 32'h5a00_0000 | 32'(p);
      #2 presetn = 1'b0;
      #1;
      check("rst_pready", 64'(apb_if.pready), 64'd0);
      check("rst_prdata", 64'(apb_if.prdata), 64'd0);
      check("rst_evt",    64'(tmout_evt),     64'd0);
      repeat (3) @(posedge pclk);
      #1 presetn = 1'b1;
      tick();

      // read port 2, ack in setup cycle: zero-wait response
      xfer(0, 2, 32'h0000_0001, 4'hf, 0, 0, 32'h1234_5678, 0, 0, 1, -1, s, r);
      check("t1_latency", 64'(r - s), 64'd1);
      check("t1_prdata",  64'(e_prdata[r]), 64'h1234_5678);
      check("t1_pslverr", 64'(e_pslverr[r]), 64'd0);

      // write port 0 with strobes, non-secure, ack three cycles later
      xfer(1, 0, 32'ha5a5_5a5a, 4'b0101, 1, 3, 32'h0, 0, 0, 1, -1, s, r);
      check("t2_latency", 64'(r - s), 64'd4);
      check("t2_strb",    64'(e_strb[s]), 64'h5);
      check("t2_prdata",  64'(e_prdata[r]), 64'd0);

      // timeout of 8 with no ack
      xfer(0, 1, 32'h0000_0002, 4'hf, 0, -1, 32'h0, 0, 8, 1, -1, s, r);
      check("t3_latency", 64'(r - s), 64'd9);
      check("t3_prdata",  64'(e_prdata[r]), 64'hdead_1eaf);
      check("t3_evt",     64'(e_evt[r]), 64'd1);

      // decode errors: index 5 read with errors enabled, index 7 write with errors masked
      xfer(0, 5, 32'h0000_0003, 4'hf, 1, -1, 32'h0, 0, 0, 1, -1, s, r);
      check("t4_latency", 64'(r - s), 64'd1);
      check("t4_req",     64'(e_req[s]), 64'd0);
      check("t4_pslverr", 64'(e_pslverr[r]), 64'd1);
      xfer(1, 7, 32'h0000_0011, 4'h3, 0, -1, 32'h0, 0, 0, 0, -1, s, r);
      check("t4b_pslverr", 64'(e_pslverr[r]), 64'd0);

      // port 3 selected; stray ack on port 1 ignored; port 3 acks with error
      xfer(0, 3, 32'h0000_0004, 4'hf, 0, 3, 32'hcafe_f00d, 1, 0, 1, 1, s, r);
      check("t5_latency", 64'(r - s), 64'd4);
      check("t5_prdata",  64'(e_prdata[r]), 64'hcafe_f00d);

      // ack on the timeout cycle wins; one cycle later it loses
      xfer(0, 2, 32'h0000_0005, 4'hf, 0, 3, 32'h0bad_cafe, 0, 3, 1, -1, s, r);
      check("t6a_evt",    64'(e_evt[r]), 64'd0);
      check("t6a_prdata", 64'(e_prdata[r]), 64'h0bad_cafe);
      xfer(0, 2, 32'h0000_0006, 4'hf, 0, 4, 32'h0bad_cafe, 0, 3, 1, -1, s, r);
      check("t6b_latency", 64'(r - s), 64'd4);
      check("t6b_prdata",  64'(e_prdata[r]), 64'hdead_1eaf);

      // slave error masked by pslverr_en=0
      xfer(0, 1, 32'h0000_0007, 4'hf, 0, 1, 32'h7777_0001, 1, 0, 0, -1, s, r);
      check("t7_pslverr", 64'(e_pslverr[r]), 64'd0);

      // reset while waiting on port 3: the aborted transfer never responds
      tick();
      s = cyc;
      fill_setup(s, 0, 3, 32'h0000_0008, 4'hf, 0);
      tmout_val = '0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         apb_if.psel = 1'b1; apb_if.penable = (k > 0); apb_if.pwrite = 1'b0;
         apb_if.paddr = paddr_of(3); apb_if.pwdata = 32'h0000_0008;
         apb_if.pstrb = 4'hf; apb_if.pprot = 3'b000;
      end
      tick();
      presetn = 1'b0; apb_if.psel = 1'b0; apb_if.penable = 1'b0;
      tick();
      tick();
      presetn = 1'b1;
      tick();
      xfer(0, 1, 32'h0000_0009, 4'hf, 0, 2, 32'h0111_2222, 0, 4, 1, -1, s, r);
      check("t8a_latency", 64'(r - s), 64'd3);
      xfer(0, 1, 32'h0000_000a, 4'hf, 0, -1, 32'h0, 0, 4, 1, -1, s, r);
      check("t8b_latency", 64'(r - s), 64'd5);

      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
